// File: rtl/cic_decimator.sv
// N-stage CIC decimator: sample-qualified integrators, strobed combs and a
// registered output taken from the top OUT_WIDTH bits of the last comb.
module cic_decimator #(
  parameter int IN_WIDTH   = 32,
  parameter int STAGES     = 4,
  parameter int RATE       = 8,
  parameter int DIFF_DELAY = 1,
  parameter int OUT_WIDTH  = 44
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        x_valid,
  input  logic signed [IN_WIDTH-1:0]  x_in,
  output logic                        y_valid,
  output logic signed [OUT_WIDTH-1:0] y_out
);

  localparam int FULL_WIDTH = IN_WIDTH + STAGES * $clog2(RATE * DIFF_DELAY);
  localparam int CNT_W      = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

  logic signed [FULL_WIDTH-1:0] integ_reg  [STAGES];
  logic signed [FULL_WIDTH-1:0] integ_next [STAGES];
  logic signed [FULL_WIDTH-1:0] comb_reg   [STAGES];
  logic signed [FULL_WIDTH-1:0] comb_in    [STAGES];
  logic signed [FULL_WIDTH-1:0] comb_next  [STAGES];
  logic signed [FULL_WIDTH-1:0] delay_reg  [STAGES][DIFF_DELAY];
  logic signed [FULL_WIDTH-1:0] x_ext;
  logic [CNT_W-1:0]             cnt_reg;
  logic                         dec_reg;
  logic                         y_valid_reg;

  assign x_ext = {{(FULL_WIDTH - IN_WIDTH){x_in[IN_WIDTH-1]}}, x_in};

  // Every stage reads only pre-edge registers, so the chains are pipelined
  // and all arithmetic wraps modulo 2^FULL_WIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign integ_next[gi] = integ_reg[gi] + x_ext;
        assign comb_in[gi]    = integ_reg[STAGES-1];
      end else begin : g_rest
        assign integ_next[gi] = integ_reg[gi] + integ_reg[gi-1];
        assign comb_in[gi]    = comb_reg[gi-1];
      end
      assign comb_next[gi] = comb_in[gi] - delay_reg[gi][DIFF_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_reg[k] <= '0;
      end
    end else if (x_valid) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_reg[k] <= integ_next[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      dec_reg <= 1'b0;
    end else begin
      dec_reg <= x_valid && (cnt_reg == CNT_LAST);
      if (x_valid) begin
        cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_reg[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) begin
          delay_reg[k][j] <= '0;
        end
      end
    end else if (dec_reg) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_reg[k]     <= comb_next[k];
        delay_reg[k][0] <= comb_in[k];
        for (int j = 1; j < DIFF_DELAY; j++) begin
          delay_reg[k][j] <= delay_reg[k][j-1];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_valid_reg <= 1'b0;
    end else begin
      y_valid_reg <= dec_reg;
    end
  end

  // The last comb register is the output register; dropping its low bits
  // truncates toward minus infinity.
  assign y_out   = comb_reg[STAGES-1][FULL_WIDTH-1 -: OUT_WIDTH];
  assign y_valid = y_valid_reg;

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Parametrised N-stage cascaded integrator-comb (CIC) decimation filter with an input valid qualifier and a registered, strobed output. It is the successor to the fixed single-rate 32-bit CIC filter: stage count, decimation ratio, differential delay and output width are all parameters. Gaps in the input stream are allowed. It sits between a sample source (ADC front end or file-driven bench) and downstream rate-reduced processing.

## Interface
- IN_WIDTH, 32, signed two's-complement input sample width
- STAGES, 4, number of integrator and comb stages N (1..8)
- RATE, 8, decimation ratio R (2..64)
- DIFF_DELAY, 1, comb differential delay M (1 or 2)
- OUT_WIDTH, 44, output width; must be ≤ FULL_WIDTH = IN_WIDTH + STAGES·ceil(log2(RATE·DIFF_DELAY))

- clock  in  1  single rising-edge clock
- reset  in  1  asynchronous, active-low reset
- x_valid  in  1  x_in holds a sample to accept this cycle
- x_in  in  IN_WIDTH  signed input sample
- y_valid  out  1  one-cycle pulse; y_out holds a new decimated sample
- y_out  out  OUT_WIDTH  signed output, MSBs of the FULL_WIDTH comb result

## Operation
- All internal arithmetic is FULL_WIDTH, two's-complement, modulo 2^FULL_WIDTH. Integrator wrap-around is intentional and is cancelled exactly by the combs. No saturation.
- Integrators:
  - Every cycle with x_valid=1, all stages update at the same time from pre-edge values: I0 ← I0 + sext(x_in); Ik ← Ik + I(k-1) for k = 1..N-1.
  - The integrators hold when x_valid=0.
- Decimation counter cnt, range 0..RATE-1:
  - Increments on each accepted sample.
  - When an accepted sample arrives with cnt = RATE-1, cnt wraps to 0 and the strobe dec is registered high for the next cycle only.
- Combs, updated only in a cycle with dec=1, all stages from pre-edge values:
  - Stage 0 input is I(N-1).
  - Ck ← in_k − D_k[M-1]; the delay line D_k shifts in in_k.
  - in_k = C(k-1) for k ≥ 1.
- Output:
  - y_out ← C(N-1)[FULL_WIDTH-1 : FULL_WIDTH-OUT_WIDTH]. The low bits are truncated toward −∞.
  - y_valid is high in the cycle after the dec cycle.
- DC gain is (R·M)^N. Steady-state output for constant input x is x·(R·M)^N >> (FULL_WIDTH − OUT_WIDTH).

## Timing
- Reset (reset=0, asynchronous assert, released synchronously to the design): all integrators, combs, delay lines, cnt, dec, y_out and y_valid go to 0.
- x_valid may be asserted back-to-back or with arbitrary gaps. No backpressure exists; every x_valid=1 cycle is consumed.
- Minimum spacing between y_valid pulses is RATE cycles, reached when x_valid is held at 1.
- Latency from the accepted sample that completes a group (cnt = RATE-1) to y_valid is 2 clock edges: dec on edge +1, y_out/y_valid on edge +2.
- Pipeline fill:
  - Stage k's integrator sees a sample k accepted samples after stage 0.
  - Comb stage k reflects a group k decimated strobes later.
  - Bit-exact behaviour follows the simultaneous-update rules above; the bench model implements exactly these rules.
- x_valid=1 during a dec cycle: the integrators update normally. The comb captures the pre-edge I(N-1).
- Reset asserted mid-operation: all state clears immediately, with no partial output. The first y_valid after release comes only after RATE new accepted samples.

## Test plan
- Reset: hold reset=0 for 3 cycles with random x_in and x_valid=1 → y_out = 0, y_valid = 0 throughout; no pulse in the first RATE+1 cycles after release.
- DC gain (defaults N=4, R=8, M=1, OUT_WIDTH=44): x_in = 1, x_valid held high → after the pipeline fills, every y_valid carries y_out = 4096; pulses exactly 8 cycles apart.
- Impulse (N=1, R=4, M=1, OUT_WIDTH=34): single x_in = 5 on the first accepted sample, then zeros → the first y_valid gives 5, all later outputs 0.
- Gapped input (defaults): x_in = 1 with x_valid toggling 1,0,1,0… → same output values as the DC test; y_valid spacing 16 cycles.
- Wrap-around (defaults): x_in = 0x8000_0000 held for 2000 cycles → integrators overflow repeatedly; steady y_out = −2^31·4096 = −2^43 (sign-extended 44-bit value 0x800_0000_0000); output matches a modular bit-exact model every pulse.
- Mid-run reset (defaults): random stream, pull reset low for 1 cycle at cycle 123 → outputs match a model restarted from zero at release; no y_valid within 2 cycles of the reset edge.
